// File: rtl/battle_core.sv
// battle_core: gameplay core of the bullet-hell battle screen.
// Owns player position/HP, monster HP, an 8-slot falling bullet field,
// collision resolution and the turn sequence (PLAYER_TURN/DODGE/WIN/DEAD).
// Ports:
//   clk, reset_n            clock, async active-low reset
//   tick_move, tick_sec     10 Hz motion/spawn enable, 1 Hz dodge-timer enable
//   key_valid, key[7:0]     ASCII key strobe from the UART decoder
//   player_pos[15:0]        {x,y} of the player box; player_size is 8
//   p_hp, p_atk, mon_hp     player HP, attack constant, monster HP
//   phase[1:0]              0 turn, 1 dodge, 2 win, 3 dead
//   bullet_index/pos/size/color/render  round-robin view of one slot per clk
module battle_core #(
  parameter int P_HP_MAX    = 100,
  parameter int MON_HP_INIT = 100,
  parameter int P_ATK       = 10,
  parameter int DODGE_SECS  = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_move,
  input  logic        tick_sec,
  input  logic        key_valid,
  input  logic [7:0]  key,
  output logic [15:0] player_pos,
  output logic [7:0]  player_size,
  output logic [7:0]  p_hp,
  output logic [7:0]  p_atk,
  output logic [7:0]  mon_hp,
  output logic [1:0]  phase,
  output logic [2:0]  bullet_index,
  output logic [15:0] bullet_pos,
  output logic [15:0] bullet_size,
  output logic [2:0]  bullet_color,
  output logic        bullet_render
);
  localparam int         NUM_SLOTS = 8;
  localparam logic [7:0] HP_MAX    = 8'(P_HP_MAX);
  localparam logic [7:0] MON_INIT  = 8'(MON_HP_INIT);
  localparam logic [7:0] ATK       = 8'(P_ATK);
  localparam logic [7:0] SECS      = 8'(DODGE_SECS);
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [7:0] K_W = 8'h77, K_A = 8'h61, K_S = 8'h73, K_D = 8'h64;
  localparam logic [7:0] K_J = 8'h6A, K_R = 8'h72;
  localparam logic [1:0] C_WHITE = 2'd0, C_BLUE = 2'd1, C_GREEN = 2'd2;

  typedef enum logic [1:0] {PH_TURN, PH_DODGE, PH_WIN, PH_DEAD} phase_t;
  typedef enum logic [2:0] {D_NONE, D_UP, D_LEFT, D_DOWN, D_RIGHT} dir_t;

  phase_t ph;
  dir_t   pend, key_dir;
  logic [7:0] px, py, timer;
  logic       moved;
  logic [1:0] cnt;
  logic [15:0] lfsr;
  logic [NUM_SLOTS-1:0]       act;
  logic [NUM_SLOTS-1:0][7:0]  bx, by;
  logic [NUM_SLOTS-1:0][1:0]  col;

  // combinational next-state helpers
  logic [NUM_SLOTS-1:0]       hit, act_mv, act_nxt;
  logic [NUM_SLOTS-1:0][7:0]  bx_nxt, by_nxt;
  logic [NUM_SLOTS-1:0][1:0]  col_nxt;
  logic signed [9:0] delta, hp_sum;
  logic [7:0] hp_new, mon_sub, mv_px, mv_py;
  logic [15:0] lfsr_nxt;
  logic       spawn_hit, expire, mv_key, atk, restart;
  logic [2:0] spawn_slot, nxt_idx;

  assign player_pos  = {px, py};
  assign player_size = 8'd8;
  assign p_atk       = ATK;
  assign bullet_size = 16'h0808;
  assign phase       = ph;
  assign nxt_idx     = bullet_index + 3'd1;

  // boxes are 8x8; widen to 9 bits so +8 never wraps
  function automatic logic overlap(input logic [7:0] ax, ay, bx_i, by_i);
    overlap = ({1'b0, ax} < {1'b0, bx_i} + 9'd8) && ({1'b0, bx_i} < {1'b0, ax} + 9'd8) &&
              ({1'b0, ay} < {1'b0, by_i} + 9'd8) && ({1'b0, by_i} < {1'b0, ay} + 9'd8);
  endfunction

  always_comb begin
    mv_key  = 1'b0;
    key_dir = D_NONE;
    if (key_valid) begin
      mv_key = 1'b1;
      case (key)
        K_W:     key_dir = D_UP;
        K_A:     key_dir = D_LEFT;
        K_S:     key_dir = D_DOWN;
        K_D:     key_dir = D_RIGHT;
        default: mv_key  = 1'b0;
      endcase
    end
    atk     = key_valid && (key == K_J);
    restart = key_valid && (key == K_R) && (ph == PH_WIN || ph == PH_DEAD);
  end

  always_comb begin
    hit   = '0;
    delta = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (act[i] && overlap(px, py, bx[i], by[i])) begin
        hit[i] = 1'b1;
        case (col[i])
          C_WHITE: delta = delta - 10'sd5;
          C_BLUE:  if (moved) delta = delta - 10'sd5;
          default: delta = delta + 10'sd5;
        endcase
      end
    end
    hp_sum = $signed({2'b00, p_hp}) + delta;
    if (hp_sum < 10'sd0)                          hp_new = 8'd0;
    else if (hp_sum > $signed({2'b00, HP_MAX}))   hp_new = HP_MAX;
    else                                          hp_new = hp_sum[7:0];

    mon_sub = (mon_hp > ATK) ? mon_hp - ATK : 8'd0;
    expire  = tick_sec && (timer + 8'd1 == SECS);

    mv_px = px;
    mv_py = py;
    case (pend)
      D_UP:    mv_py = (py < 8'd104) ? 8'd100 : py - 8'd4;
      D_DOWN:  mv_py = (py > 8'd187) ? 8'd191 : py + 8'd4;
      D_LEFT:  mv_px = (px < 8'd44)  ? 8'd40  : px - 8'd4;
      D_RIGHT: mv_px = (px > 8'd203) ? 8'd207 : px + 8'd4;
      default: ;
    endcase

    // collisions retire slots first, then survivors fall, then spawn fills a hole
    act_mv = act & ~hit;
    bx_nxt = bx;
    by_nxt = by;
    col_nxt = col;
    if (tick_move) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (act_mv[i]) begin
          by_nxt[i] = by[i] + 8'd4;
          if (({1'b0, by[i]} + 9'd4) > 9'd191) act_mv[i] = 1'b0;
        end
      end
    end
    spawn_hit  = 1'b0;
    spawn_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!act_mv[i]) begin
        spawn_hit  = 1'b1;
        spawn_slot = 3'(i);
      end
    end
    act_nxt = act_mv;
    // spawn uses the LFSR value present before this tick's advance
    if (tick_move && cnt == 2'd3 && spawn_hit) begin
      act_nxt[spawn_slot] = 1'b1;
      bx_nxt[spawn_slot]  = 8'd40 + {1'b0, lfsr[6:0]};
      by_nxt[spawn_slot]  = 8'd100;
      case (lfsr[9:8])
        2'b10:   col_nxt[spawn_slot] = C_BLUE;
        2'b11:   col_nxt[spawn_slot] = C_GREEN;
        default: col_nxt[spawn_slot] = C_WHITE;
      endcase
    end
    lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph <= PH_TURN;  pend <= D_NONE;  px <= 8'd128;  py <= 8'd150;
      p_hp <= HP_MAX; mon_hp <= MON_INIT; timer <= '0; moved <= 1'b0;
      cnt <= '0;      lfsr <= SEED;    act <= '0;     bx <= '0; by <= '0; col <= '0;
      bullet_index <= '0; bullet_pos <= '0; bullet_color <= '0; bullet_render <= 1'b0;
    end else begin
      case (ph)
        PH_TURN: begin
          if (mv_key) pend <= key_dir;
          if (atk) begin
            mon_hp <= mon_sub;
            ph     <= (mon_sub == 8'd0) ? PH_WIN : PH_DODGE;
            timer  <= '0;
          end
        end
        PH_DODGE: begin
          // a zero HP seen here wins over everything else this cycle
          if (p_hp == 8'd0) ph <= PH_DEAD;
          else begin
            bx  <= bx_nxt;
            by  <= by_nxt;
            col <= col_nxt;
            if (expire) begin
              act <= '0;
              ph  <= PH_TURN;
            end else begin
              act  <= act_nxt;
              p_hp <= hp_new;
            end
            if (tick_move) begin
              px    <= mv_px;
              py    <= mv_py;
              moved <= (mv_px != px) || (mv_py != py);
              cnt   <= cnt + 2'd1;
              lfsr  <= lfsr_nxt;
            end
            // a key on the tick edge is held for the next tick
            if (mv_key)         pend <= key_dir;
            else if (tick_move) pend <= D_NONE;
            if (tick_sec) timer <= timer + 8'd1;
          end
        end
        default: begin
          if (restart) begin
            ph <= PH_TURN;  pend <= D_NONE;  px <= 8'd128;  py <= 8'd150;
            p_hp <= HP_MAX; mon_hp <= MON_INIT; timer <= '0; moved <= 1'b0;
            cnt <= '0;      lfsr <= SEED;    act <= '0;     bx <= '0; by <= '0; col <= '0;
          end
        end
      endcase

      bullet_index <= nxt_idx;
      if (restart) begin
        bullet_pos    <= '0;
        bullet_color  <= '0;
        bullet_render <= 1'b0;
      end else begin
        bullet_pos    <= {bx[nxt_idx], by[nxt_idx]};
        bullet_color  <= {1'b0, col[nxt_idx]};
        bullet_render <= act[nxt_idx];
      end
    end
  end
endmodule

// File: tb/tb_battle_core.sv
`timescale 1ns/1ps
module tb_battle_core;
  localparam logic [7:0] KW = 8'h77, KA = 8'h61, KS = 8'h73, KD = 8'h64, KJ = 8'h6A, KR = 8'h72;

  logic clk, reset_n, tick_move, tick_sec, key_valid;
  logic [7:0] key;
  logic [15:0] player_pos, bullet_pos, bullet_size;
  logic [7:0] player_size, p_hp, p_atk, mon_hp;
  logic [1:0] phase;
  logic [2:0] bullet_index, bullet_color;
  logic bullet_render;

  battle_core dut (
    .clk(clk), .reset_n(reset_n), .tick_move(tick_move), .tick_sec(tick_sec),
    .key_valid(key_valid), .key(key), .player_pos(player_pos), .player_size(player_size),
    .p_hp(p_hp), .p_atk(p_atk), .mon_hp(mon_hp), .phase(phase), .bullet_index(bullet_index),
    .bullet_pos(bullet_pos), .bullet_size(bullet_size), .bullet_color(bullet_color),
    .bullet_render(bullet_render)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // reference model: game rules stated directly in integers
  int m_px, m_py, m_hp, m_mon, m_phase, m_pend, m_moved, m_cnt, m_timer, m_idx;
  int m_act[8], m_bx[8], m_by[8], m_col[8];
  int m_ppx, m_ppy, m_pcol, m_pren;
  logic [15:0] m_lfsr;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input bit keep_idx);
    m_px = 128; m_py = 150; m_hp = 100; m_mon = 100; m_phase = 0; m_pend = 0;
    m_moved = 0; m_cnt = 0; m_timer = 0; m_lfsr = 16'hACE1;
    for (int i = 0; i < 8; i++) begin m_act[i] = 0; m_bx[i] = 0; m_by[i] = 0; m_col[i] = 0; end
    m_ppx = 0; m_ppy = 0; m_pcol = 0; m_pren = 0;
    if (!keep_idx) m_idx = 0;
  endtask

  task automatic model_step(input bit kv, input logic [7:0] k, input bit tm, input bit ts);
    int n, delta, ox, oy, qx, qy, qc, qr;
    bit mv, rst, done;
    n = (m_idx + 1) % 8;
    qx = m_bx[n]; qy = m_by[n]; qc = m_col[n]; qr = m_act[n];
    mv = kv && (k == KW || k == KA || k == KS || k == KD);
    rst = 0;
    case (m_phase)
      0: begin
        if (mv) m_pend = k;
        if (kv && k == KJ) begin
          m_mon = (m_mon > 10) ? m_mon - 10 : 0;
          m_phase = (m_mon == 0) ? 2 : 1;
          m_timer = 0;
        end
      end
      1: begin
        if (m_hp == 0) m_phase = 3;
        else begin
          delta = 0;
          for (int i = 0; i < 8; i++)
            if (m_act[i] && m_px < m_bx[i] + 8 && m_bx[i] < m_px + 8 &&
                m_py < m_by[i] + 8 && m_by[i] < m_py + 8) begin
              m_act[i] = 0;
              if (m_col[i] == 0) delta -= 5;
              else if (m_col[i] == 1) begin if (m_moved) delta -= 5; end
              else delta += 5;
            end
          if (tm) begin
            ox = m_px; oy = m_py;
            if (m_pend == KW) m_py = (m_py - 4 < 100) ? 100 : m_py - 4;
            if (m_pend == KS) m_py = (m_py + 4 > 191) ? 191 : m_py + 4;
            if (m_pend == KA) m_px = (m_px - 4 < 40) ? 40 : m_px - 4;
            if (m_pend == KD) m_px = (m_px + 4 > 207) ? 207 : m_px + 4;
            m_moved = (m_px != ox || m_py != oy);
            for (int i = 0; i < 8; i++)
              if (m_act[i]) begin m_by[i] += 4; if (m_by[i] > 191) m_act[i] = 0; end
            m_cnt = (m_cnt + 1) % 4;
            done = 0;
            if (m_cnt == 0)
              for (int i = 0; i < 8; i++)
                if (!done && !m_act[i]) begin
                  done = 1; m_act[i] = 1; m_bx[i] = 40 + m_lfsr[6:0]; m_by[i] = 100;
                  m_col[i] = (m_lfsr[9:8] == 2) ? 1 : (m_lfsr[9:8] == 3) ? 2 : 0;
                end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_pend = 0;
          end
          if (mv) m_pend = k;
          if (ts) begin
            m_timer++;
            if (m_timer == 5) begin
              for (int i = 0; i < 8; i++) m_act[i] = 0;
              m_phase = 0; delta = 0;
            end
          end
          m_hp += delta;
          if (m_hp < 0) m_hp = 0;
          if (m_hp > 100) m_hp = 100;
        end
      end
      default: if (kv && k == KR) begin model_reset(1); rst = 1; end
    endcase
    m_idx = n;
    if (rst) begin m_ppx = 0; m_ppy = 0; m_pcol = 0; m_pren = 0; end
    else begin m_ppx = qx; m_ppy = qy; m_pcol = qc; m_pren = qr; end
  endtask

  task automatic compare_all();
    check("pos_x", player_pos[15:8], m_px);
    check("pos_y", player_pos[7:0], m_py);
    check("p_hp", p_hp, m_hp);
    check("mon_hp", mon_hp, m_mon);
    check("phase", phase, m_phase);
    check("b_index", bullet_index, m_idx);
    check("b_x", bullet_pos[15:8], m_ppx);
    check("b_y", bullet_pos[7:0], m_ppy);
    check("b_color", bullet_color, m_pcol);
    check("b_render", bullet_render, m_pren);
    check("consts", {player_size, p_atk, bullet_size}, {8'd8, 8'd10, 16'h0808});
  endtask

  task automatic cycle(input bit kv, input logic [7:0] k, input bit tm, input bit ts);
    key_valid = kv; key = k; tick_move = tm; tick_sec = ts;
    @(posedge clk);
    model_step(kv, k, tm, ts);
    #1;
    key_valid = 0; key = 8'h00; tick_move = 0; tick_sec = 0;
    compare_all();
  endtask

  // one idle cycle so the view is fresh, then spin until slot 0 is shown
  task automatic wait_idx0();
    cycle(0, 8'h00, 0, 0);
    for (int i = 0; i < 9 && bullet_index != 0; i++) cycle(0, 8'h00, 0, 0);
    check("idx_reach0", bullet_index, 0);
  endtask

  task automatic random_run(input int n);
    logic [7:0] keys [8];
    keys[0] = KW; keys[1] = KA; keys[2] = KS; keys[3] = KD;
    keys[4] = KJ; keys[5] = KR; keys[6] = 8'h78; keys[7] = 8'h00;
    for (int c = 0; c < n; c++)
      cycle($urandom_range(3) == 0, keys[$urandom_range(7)],
            $urandom_range(3) == 0, $urandom_range(15) == 0);
  endtask

  // steer toward the nearest harmful bullet still above the player
  task automatic hunt_to_death();
    int tgt, best, d, dx, dy;
    logic [7:0] k;
    for (int it = 0; it < 3000 && m_phase != 3; it++) begin
      tgt = -1; best = 100000;
      for (int i = 0; i < 8; i++)
        if (m_act[i] && m_col[i] != 2 && m_by[i] < m_py + 8) begin
          d = (m_bx[i] > m_px ? m_bx[i] - m_px : m_px - m_bx[i]) +
              (m_by[i] > m_py ? m_by[i] - m_py : m_py - m_by[i]);
          if (d < best) begin best = d; tgt = i; end
        end
      if (tgt >= 0) begin
        dx = m_bx[tgt] - m_px; dy = m_by[tgt] - m_py;
        if ((dx < 0 ? -dx : dx) >= (dy < 0 ? -dy : dy)) k = (dx > 0) ? KD : KA;
        else k = (dy > 0) ? KS : KW;
        cycle(1, k, 0, 0);
      end else if (m_py > 120) cycle(1, KW, 0, 0);
      cycle(0, 8'h00, 1, 0);
      cycle(0, 8'h00, 0, 0);
    end
    check("dead_phase", phase, 3);
    check("dead_hp", p_hp, 0);
  endtask

  typedef struct {
    bit kv; logic [7:0] k; bit tm; bit ts;
    int ph; int mon; int x; int y;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{0, 8'h00, 0, 0, 0, 100, 128, 150};
    tbl[1]  = '{1, KJ,    0, 0, 1,  90, 128, 150};
    tbl[2]  = '{1, KD,    0, 0, 1,  90, 128, 150};
    tbl[3]  = '{0, 8'h00, 1, 0, 1,  90, 132, 150};
    tbl[4]  = '{1, KW,    1, 0, 1,  90, 132, 150};  // key held for next tick
    tbl[5]  = '{0, 8'h00, 1, 0, 1,  90, 132, 146};
    tbl[6]  = '{0, 8'h00, 0, 1, 1,  90, 132, 146};
    tbl[7]  = '{0, 8'h00, 0, 1, 1,  90, 132, 146};
    tbl[8]  = '{0, 8'h00, 0, 1, 1,  90, 132, 146};
    tbl[9]  = '{0, 8'h00, 0, 1, 1,  90, 132, 146};
    tbl[10] = '{0, 8'h00, 0, 1, 0,  90, 132, 146};  // fifth second ends dodge
    tbl[11] = '{1, 8'h78, 0, 0, 0,  90, 132, 146};
    tbl[12] = '{1, KR,    0, 0, 0,  90, 132, 146};  // restart refused mid-game
    tbl[13] = '{1, KJ,    0, 0, 1,  80, 132, 146};

    reset_n = 0; key_valid = 0; key = 8'h00; tick_move = 0; tick_sec = 0;
    model_reset(0);
    #12;
    compare_all();
    check("rst_phase", phase, 0);
    check("rst_pos", player_pos, {8'd128, 8'd150});
    @(posedge clk); #1;
    reset_n = 1;

    foreach (tbl[i]) begin
      cycle(tbl[i].kv, tbl[i].k, tbl[i].tm, tbl[i].ts);
      check("tbl_phase", phase, tbl[i].ph);
      check("tbl_mon", mon_hp, tbl[i].mon);
      check("tbl_x", player_pos[15:8], tbl[i].x);
      check("tbl_y", player_pos[7:0], tbl[i].y);
    end

    // 4th move tick in dodge: LFSR 0xACE1 advanced 3x is 0x670F -> x=40+15, green
    cycle(0, 8'h00, 1, 0);
    wait_idx0();
    check("spawn_x", bullet_pos[15:8], 55);
    check("spawn_y", bullet_pos[7:0], 100);
    check("spawn_col", bullet_color, 2);
    check("spawn_ren", bullet_render, 1);
    repeat (22) cycle(0, 8'h00, 1, 0);
    wait_idx0();
    check("fall_y188", bullet_pos[7:0], 188);
    check("fall_ren", bullet_render, 1);
    cycle(0, 8'h00, 1, 0);
    wait_idx0();
    check("freed_ren", bullet_render, 0);

    // timer expiry, last second coincident with a move tick
    repeat (4) cycle(0, 8'h00, 0, 1);
    check("timer_4", phase, 1);
    cycle(0, 8'h00, 1, 1);
    check("timer_5", phase, 0);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 8'h00, 0, 0);
      check("sweep_ren", bullet_render, 0);
    end

    // fight to a win from mon_hp 80
    for (int r = 0; r < 8; r++) begin
      cycle(1, KJ, 0, 0);
      if (r < 7) repeat (5) cycle(0, 8'h00, 0, 1);
    end
    check("win_mon", mon_hp, 0);
    check("win_phase", phase, 2);
    cycle(1, KJ, 0, 0);
    check("win_j_ign", mon_hp, 0);
    cycle(1, KD, 0, 0);
    cycle(0, 8'h00, 1, 0);
    check("win_frozen", player_pos[15:8], 132);
    cycle(1, KR, 0, 0);
    check("rs_phase", phase, 0);
    check("rs_mon", mon_hp, 100);
    check("rs_hp", p_hp, 100);
    check("rs_pos", player_pos, {8'd128, 8'd150});

    // arena walls
    cycle(1, KJ, 0, 0);
    repeat (25) begin cycle(1, KA, 0, 0); cycle(0, 8'h00, 1, 0); end
    check("wall_left", player_pos[15:8], 40);
    repeat (45) begin cycle(1, KD, 0, 0); cycle(0, 8'h00, 1, 0); end
    check("wall_right", player_pos[15:8], 207);
    repeat (15) begin cycle(1, KW, 0, 0); cycle(0, 8'h00, 1, 0); end
    check("wall_top", player_pos[7:0], 100);

    hunt_to_death();
    cycle(1, KR, 0, 0);
    check("rd_phase", phase, 0);
    check("rd_hp", p_hp, 100);
    check("rd_mon", mon_hp, 100);

    random_run(3000);

    // asynchronous reset in the middle of play
    @(posedge clk); #3;
    reset_n = 0;
    #1;
    model_reset(0);
    compare_all();
    @(posedge clk); #1;
    reset_n = 1;
    random_run(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
